// File: rtl/writeback_arbiter.sv
// Register-file write-port owner: ALU results take priority over buffered load results; tracks outstanding loads.
// Latency: ALU result 1 edge to regWrite; load result 2 edges (push, then pop) when uncontended.
// Backpressure: ALU path never stalls; load path is valid/ready, mem_ready low only while the FIFO is full.

module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDR_WIDTH-1:0]         alu_addr,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_addr,
    output logic                          regWrite,
    output logic [ADDR_WIDTH-1:0]         writeAddress,
    output logic [DATA_WIDTH-1:0]         writeInputData,
    output logic [31:0]                   busy_vec,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } load_t;

    load_t push_ent;
    load_t head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  pop;

    assign push_ent  = '{addr: mem_addr, dat: mem_data};
    assign mem_ready = reset && !fifo_full;
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && !fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(load_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    logic                  sel_vld;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  sel_we;

    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        sel_dat  = '0;
        if (alu_valid) begin
            sel_vld  = 1'b1;
            sel_addr = alu_addr;
            sel_dat  = alu_data;
        end else if (!fifo_empty) begin
            sel_vld  = 1'b1;
            sel_addr = head.addr;
            sel_dat  = head.dat;
        end
    end

    // Writes to r0 are swallowed; address/data only move on a real write.
    assign sel_we = sel_vld && (sel_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite       <= 1'b0;
            writeAddress   <= '0;
            writeInputData <= '0;
        end else begin
            regWrite <= sel_we;
            if (sel_we) begin
                writeAddress   <= sel_addr;
                writeInputData <= sel_dat;
            end
        end
    end

    logic [31:0] busy_nxt;

    // Clear first so a same-edge issue to the popped register stays pending.
    always_comb begin
        busy_nxt = busy_vec;
        if (pop)
            busy_nxt[head.addr] = 1'b0;
        if (issue_valid && (issue_addr != '0))
            busy_nxt[issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_vec <= '0;
        else        busy_vec <= busy_nxt;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          regWrite;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeInputData;
    logic [31:0]   busy_vec;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .issue_valid    (issue_valid),
        .issue_addr     (issue_addr),
        .regWrite       (regWrite),
        .writeAddress   (writeAddress),
        .writeInputData (writeInputData),
        .busy_vec       (busy_vec),
        .fifo_count     (fifo_count)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ld_t;

    // Reference model: ordered load buffer, pending-register set, expected writes.
    wr_t           exp_q[$];
    ld_t           fifo_m[$];
    logic [31:0]   busy_m = '0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;
    int            cyc   = 0;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            check("mem_ready", 64'(mem_ready), 64'(rst_n && (fifo_m.size() < DEPTH)));
            check("fifo_count", 64'(fifo_count), 64'(fifo_m.size()));
            check("busy_vec", 64'(busy_vec), 64'(busy_m));
            if (regWrite) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write cyc=%0d got addr=%0d data=%0h want none",
                             cyc, writeAddress, writeInputData);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                    check("write_addr", 64'(writeAddress), 64'(e.a));
                    check("write_data", 64'(writeInputData), 64'(e.d));
                end
            end else begin
                check("hold_addr", 64'(writeAddress), 64'(last_a));
                check("hold_data", 64'(writeInputData), 64'(last_d));
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missed_write cyc=%0d got regWrite=0 want addr=%0d data=%0h",
                             cyc, e.a, e.d);
                end
            end
            cyc++;
        end
    end

    // One clock edge of stimulus; the model applies the same edge using queue semantics.
    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input bit iv, input logic [AW-1:0] ia, output bit acc);
        ld_t h;
        @(negedge clk);
        #1;
        alu_valid   = av;
        alu_addr    = aa;
        alu_data    = ad;
        mem_valid   = mv;
        mem_addr    = ma;
        mem_data    = md;
        issue_valid = iv;
        issue_addr  = ia;
        acc = mv && (fifo_m.size() < DEPTH);
        if (av) begin
            if (aa != 0) begin
                exp_q.push_back('{aa, ad, cyc});
                last_a = aa;
                last_d = ad;
            end
        end else if (fifo_m.size() > 0) begin
            h = fifo_m.pop_front();
            busy_m[h.a] = 1'b0;
            if (h.a != 0) begin
                exp_q.push_back('{h.a, h.d, cyc});
                last_a = h.a;
                last_d = h.d;
            end
        end
        if (iv && ia != 0) busy_m[ia] = 1'b1;
        if (acc) fifo_m.push_back('{ma, md});
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        mem_addr    = '0;
        mem_data    = '0;
        issue_addr  = '0;
        fifo_m.delete();
        exp_q.delete();
        busy_m = '0;
        last_a = '0;
        last_d = '0;
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int idx;
        int guard;
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        step(1, 5, 55, 0, 0, 0, 0, 0, acc);
        idle(2);

        step(0, 0, 0, 0, 0, 0, 1, 7, acc);
        idle(1);
        step(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, acc);
        idle(3);

        // ALU hogs the port while loads stack up until the buffer fills.
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, AW'(1 + i), DW'(32'h100 + i), 1, AW'(10 + idx), DW'(32'hA000 + idx), 0, 0, acc);
            if (acc) idx++;
        end
        guard = 0;
        while (idx < 5 && guard < 10) begin
            step(0, 0, 0, 1, AW'(10 + idx), DW'(32'hA000 + idx), 0, 0, acc);
            if (acc) idx++;
            guard++;
        end
        idle(8);

        step(1, 0, 32'h1111, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 1, 0, 32'h2222, 0, 0, acc);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1, 9, acc);
        step(0, 0, 0, 1, 9, 32'h9999, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 9, acc);
        idle(2);

        for (int i = 0; i < 3; i++)
            step(1, AW'(20 + i), DW'(32'hC0 + i), 1, AW'(3 + i), DW'(32'hB0 + i), 1, AW'(3 + i), acc);
        do_reset(1);
        idle(5);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 3, AW'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 9) < 3, AW'($urandom_range(0, 31)), acc);
            if (i == 700) do_reset(2);
        end
        idle(8);

        @(negedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side driver for the MIPS datapath's 32x32 register file: owns the single write port (regWrite / writeAddress / writeInputData) and arbitrates between single-cycle ALU results and variable-latency load results. Load results are buffered in a small FIFO behind a valid/ready handshake. A busy scoreboard tracks registers with outstanding loads for the hazard logic. Outputs are registered and connect directly to the register file write port.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers)
- FIFO_DEPTH, 4, load-result buffer entries (power of two, >= 2)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result present this cycle (always accepted, no backpressure)
- alu_addr  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  load result can be accepted
- mem_addr  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- issue_valid  input  1  load issued this cycle; marks destination pending
- issue_addr  input  ADDR_WIDTH  destination of the issued load
- regWrite  output  1  write strobe to register file
- writeAddress  output  ADDR_WIDTH  write address to register file
- writeInputData  output  DATA_WIDTH  write data to register file
- busy_vec  output  32  bit k = 1 while a load to register k is outstanding
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Load path:
  - mem_ready = reset high AND fifo_count != FIFO_DEPTH. No combinational path from mem_valid.
  - Push on mem_valid && mem_ready at a rising edge.
  - Every load result passes through the FIFO; there is no same-cycle bypass.
- Arbitration each edge, with fixed priority ALU > FIFO head:
  - alu_valid: load the write registers from alu_addr/alu_data. FIFO does not pop.
  - else FIFO non-empty: pop the head and load the write registers from it.
  - else: regWrite = 0.
- Register 0:
  - A selected write with address 0 yields regWrite = 0.
  - A FIFO entry addressed to 0 is still popped.
- Write hold:
  - regWrite is a one-cycle pulse per write.
  - writeAddress/writeInputData hold their last value while regWrite = 0.
- Scoreboard:
  - issue_valid with issue_addr != 0 sets busy_vec[issue_addr].
  - A FIFO pop clears busy_vec[popped addr].
  - Set and clear to the same address at the same edge: set wins.
  - ALU writes never modify busy_vec.
  - busy_vec[0] is constant 0.
- Occupancy:
  - Push and pop at the same edge leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset assertion (async): regWrite=0, writeAddress=0, writeInputData=0, busy_vec=0, fifo_count=0, FIFO pointers=0, mem_ready=0.
- mem_ready rises combinationally once reset deasserts.
- Reset mid-operation discards all FIFO entries and any pending write. No write pulse occurs after reset.
- ALU latency: alu_valid sampled at edge N gives regWrite high during cycle N..N+1.
- Load latency, uncontended: accepted at edge N, popped at edge N+1, regWrite high after N+1.
- Contention: each cycle of alu_valid delays the FIFO head by one cycle. Sustained alu_valid with sustained loads fills the FIFO, then mem_ready drops.
- Full FIFO with a pop at edge N: mem_ready is high in cycle N..N+1. A push at the same edge as a pop is legal when not full.
- Throughput: at most one register write per cycle.

## Test plan
- Reset then idle: release reset -> mem_ready=1, regWrite=0, busy_vec=0, fifo_count=0 for 10 cycles.
- ALU write: alu_valid=1, alu_addr=5, alu_data=55 for one cycle -> next cycle regWrite=1, writeAddress=5, writeInputData=55; following cycle regWrite=0, address/data held.
- Load with scoreboard: issue_addr=7 issued -> busy_vec[7]=1. Then mem push addr=7, data=0xDEADBEEF -> write appears 2 edges after push and busy_vec[7] clears at the same edge.
- Contention and full: alu_valid held high for 6 cycles while 5 loads are offered -> 4 accepted, then mem_ready=0, fifo_count=4. After the ALU stops, 4 load writes appear in push order on consecutive cycles.
- Register 0: ALU write to 0 and load to 0 -> regWrite stays 0, FIFO still drains, busy_vec[0]=0. Issue and pop to register 9 at the same edge -> busy_vec[9]=1.
- Reset mid-operation: FIFO holding 3 entries, assert reset for 1 cycle -> all outputs return to reset values, no further writes, fifo_count=0.
